// File: rtl/mem_bus_pkg.sv
// Shared types for the core data memory bus.
// Used by the responder and the core-side master.
package mem_bus_pkg;

    localparam int WORD_W = 32;

    typedef logic [3:0] strb_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte-lane write enables.
// Read is asynchronous; contents are never reset.
module byte_lane_ram
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  strb_t             we,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // write only the enabled byte lanes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder with wait states.
// Valid/ready request and response, byte strobes, errors.
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [29:0]       word_q, word_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    strb_t             strb_q, strb_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              commit;
    logic              c_write;
    logic [29:0]       c_word;
    logic [WORD_W-1:0] c_wdata;
    strb_t             c_strb;
    logic              c_err;
    strb_t             ram_we;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    assign req_ready  = reset && (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;

    // commit operands: live inputs when committing at acceptance
    always_comb begin
        c_write = write_q;
        c_word  = word_q;
        c_wdata = wdata_q;
        c_strb  = strb_q;
        if (state_q == IDLE) begin
            c_write = req_write;
            c_word  = req_addr[31:2];
            c_wdata = req_wdata;
            c_strb  = req_strb;
        end
    end

    assign c_err = ({2'b00, c_word} >= 32'(DEPTH))
                || (c_strb == 4'b0000);
    assign ram_we = (commit && c_write && !c_err) ? c_strb : 4'b0000;

    byte_lane_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .addr  (c_word[AW-1:0]),
        .we    (ram_we),
        .wdata (c_wdata),
        .rdata (ram_rdata)
    );

    // next state, wait counter, capture and response values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    word_d  = req_addr[31:2];
                    wdata_d = req_wdata;
                    strb_d  = req_strb;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = c_err;
            rdata_d = (!c_err && !c_write) ? ram_rdata : '0;
        end
    end

    // state and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder.
// Two instances: WAIT_STATES=2 and WAIT_STATES=0.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_strb;
    logic        b_resp_valid, b_resp_ready, b_resp_err, b_busy;
    logic [31:0] b_resp_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m  [DEPTH];
    logic [31:0] mem0_m [DEPTH];

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_write  (b_req_write),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .req_strb   (b_req_strb),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err),
        .busy       (b_busy)
    );

    // Reference memory: one request applied atomically.
    task automatic model_op(input bit sel, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s,
                            output logic [31:0] rd, output logic e);
        int unsigned idx;
        logic [31:0] cur;
        idx = int'(a >> 2);
        e = (idx >= DEPTH) || (s == 4'b0000);
        rd = 32'h0;
        if (!e) begin
            cur = sel ? mem0_m[idx] : mem_m[idx];
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
                if (sel) mem0_m[idx] = cur;
                else mem_m[idx] = cur;
            end else begin
                rd = cur;
            end
        end
    endtask

    task automatic gen_op(input int k, output logic w,
                          output logic [31:0] a, output logic [31:0] d,
                          output logic [3:0] s);
        d = $urandom;
        if (k < 16) begin
            w = 1'b1;
            a = 32'(k) << 2;
            s = 4'hF;
        end else begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                a = $urandom | 32'h0000_0400;
            else
                a = (32'($urandom_range(0, 15)) << 2)
                  | 32'($urandom_range(0, 3));
            s = 4'($urandom_range(0, 15));
        end
    endtask

    // One transaction on the WAIT_STATES=2 instance.
    task automatic xact(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic e,
                        output int lat);
        int g;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr = a;
        req_wdata = d;
        req_strb = s;
        resp_ready = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr = $urandom;
        req_wdata = $urandom;
        req_strb = 4'($urandom);
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        e = resp_err;
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL xact_timeout addr=%h no response", a);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0
            || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL resp_clear got v=%b d=%h e=%b want 0 0 0",
                     resp_valid, resp_rdata, resp_err);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_strb = '0; resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
        b_req_wdata = '0; b_req_strb = '0; b_resp_ready = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, busy} !== 4'b0000
            || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b v=%b e=%b busy=%b d=%h",
                     req_ready, resp_valid, resp_err, busy, resp_rdata);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || b_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b/%b want 0/0",
                     req_ready, b_req_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready got %b/%b want 1/1",
                     req_ready, b_req_ready);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd, erd;
        logic e, ee;
        int lat;
        model_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, ee);
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
        checks++;
        if (lat !== 3 || e !== ee || rd !== erd) begin
            errors++;
            $display("FAIL store lat=%0d e=%b d=%h want 3 %b %h",
                     lat, e, rd, ee, erd);
        end
        model_op(0, 1'b0, 32'h10, 32'h0, 4'hF, erd, ee);
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load lat=%0d e=%b d=%h want 3 0 deadbeef",
                     lat, e, rd);
        end
    endtask

    task automatic test_partial;
        logic [31:0] rd, erd;
        logic e, ee;
        int lat;
        model_op(0, 1'b1, 32'h20, 32'h11223344, 4'hF, erd, ee);
        xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e, lat);
        model_op(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, erd, ee);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL partial_store e=%b d=%h want 0 0", e, rd);
        end
        xact(1'b0, 32'h22, 32'h0, 4'b0001, rd, e, lat);
        checks++;
        if (rd !== 32'h11BB33DD || e !== 1'b0) begin
            errors++;
            $display("FAIL partial_load d=%h e=%b want 11bb33dd 0", rd, e);
        end
    endtask

    task automatic test_error;
        logic [31:0] rd, erd;
        logic e, ee;
        int lat;
        xact(1'b0, 32'h400, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_range e=%b d=%h want 1 0", e, rd);
        end
        xact(1'b0, 32'h4000_0010, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_high_addr e=%b d=%h want 1 0", e, rd);
        end
        xact(1'b1, 32'h4000_0020, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL err_high_store e=%b want 1", e);
        end
        xact(1'b0, 32'h3FC, 32'h0, 4'h1, rd, e, lat);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL err_last_word e=%b want 0", e);
        end
        model_op(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, erd, ee);
        xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_strb0 e=%b d=%h want 1 0", e, rd);
        end
        model_op(0, 1'b0, 32'h20, 32'h0, 4'hF, erd, ee);
        xact(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (rd !== erd || e !== 1'b0) begin
            errors++;
            $display("FAIL strb0_untouched d=%h want %h", rd, erd);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, erd;
        logic e, ee;
        int lat, g;
        model_op(0, 1'b0, 32'h10, 32'h0, 4'hF, erd, ee);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        req_strb = 4'hF; resp_ready = 1'b0;
        @(negedge clk);
        req_write = 1'b1; req_wdata = 32'h0BADF00D;
        g = 0;
        while (!resp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== erd
                || req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d v=%b d=%h rdy=%b want 1 %h 0",
                         i, resp_valid, resp_rdata, req_ready, erd);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release v=%b d=%h busy=%b want 0 0 0",
                     resp_valid, resp_rdata, busy);
        end
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (rd !== erd) begin
            errors++;
            $display("FAIL bp_ignored_store d=%h want %h", rd, erd);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, erd;
        logic e, ee;
        int lat, g;
        model_op(0, 1'b1, 32'h30, 32'h5A5A1234, 4'hF, erd, ee);
        xact(1'b1, 32'h30, 32'h5A5A1234, 4'hF, rd, e, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
        req_wdata = 32'hFFFF0000; req_strb = 4'hF; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, busy} !== 4'b0000
            || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait rdy=%b v=%b e=%b busy=%b d=%h",
                     req_ready, resp_valid, resp_err, busy, resp_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        model_op(0, 1'b0, 32'h30, 32'h0, 4'hF, erd, ee);
        xact(1'b0, 32'h30, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (rd !== 32'h5A5A1234) begin
            errors++;
            $display("FAIL rst_wait_discard d=%h want 5a5a1234", rd);
        end
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h34;
        req_wdata = 32'hC0FFEE00; req_strb = 4'hF; resp_ready = 1'b0;
        model_op(0, 1'b1, 32'h34, 32'hC0FFEE00, 4'hF, erd, ee);
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (!resp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp v=%b busy=%b want 0 0", resp_valid, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        resp_ready = 1'b1;
        xact(1'b0, 32'h34, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (rd !== 32'hC0FFEE00) begin
            errors++;
            $display("FAIL rst_resp_persist d=%h want c0ffee00", rd);
        end
    endtask

    task automatic test_random;
        logic w, e, ee;
        logic [31:0] a, d, rd, erd;
        logic [3:0] s;
        int lat;
        for (int k = 0; k < 56; k++) begin
            gen_op(k, w, a, d, s);
            model_op(0, w, a, d, s, erd, ee);
            xact(w, a, d, s, rd, e, lat);
            checks++;
            if (rd !== erd || e !== ee || lat !== 3) begin
                errors++;
                $display("FAIL rand%0d a=%h d=%h e=%b lat=%0d want %h %b 3",
                         k, a, rd, e, lat, erd, ee);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d [$];
        logic        exp_e [$];
        logic w, ee;
        logic [31:0] a, d, erd;
        logic [3:0] s;
        int n, last_acc;
        bit need_new, done;
        n = 0;
        last_acc = -1;
        done = 0;
        need_new = 1;
        b_resp_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (need_new) begin
                need_new = 0;
                if (n < 40) begin
                    gen_op(n, w, a, d, s);
                    b_req_valid = 1'b1; b_req_write = w; b_req_addr = a;
                    b_req_wdata = d; b_req_strb = s;
                end else begin
                    b_req_valid = 1'b0;
                end
            end
            if (b_resp_valid) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious cyc=%0d", cyc);
                end else begin
                    erd = exp_d.pop_front();
                    ee = exp_e.pop_front();
                    if (b_resp_rdata !== erd || b_resp_err !== ee
                        || cyc != last_acc + 1) begin
                        errors++;
                        $display("FAIL b2b_resp cyc=%0d d=%h e=%b want %h %b",
                                 cyc, b_resp_rdata, b_resp_err, erd, ee);
                    end
                end
            end
            if (b_req_ready && b_req_valid) begin
                model_op(1, b_req_write, b_req_addr, b_req_wdata,
                         b_req_strb, erd, ee);
                exp_d.push_back(erd);
                exp_e.push_back(ee);
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 2) begin
                        errors++;
                        $display("FAIL b2b_rate gap=%0d want 2",
                                 cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n++;
                need_new = 1;
            end
            if (n == 40 && exp_d.size() == 0 && !b_resp_valid)
                done = 1;
        end
        b_req_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL b2b_timeout accepted=%0d want 40", n);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_partial();
        test_error();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
